midi_io: RTL and testbench

MIDI_IO -- requirements
Module: midi_io

---
 rtl/midi_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 40 ++++
 rtl/midi_io.sv | 249 ++++++++++++++++++++++++
 tb/tb_midi_io.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, message-length helper and FSM state types for midi_io.
package midi_pkg;

    localparam logic [7:0] STATUS_MIN    = 8'h80;
    localparam logic [7:0] SYSTEM_MIN    = 8'hF0;
    localparam logic [7:0] TWO_BYTE_MIN  = 8'hC0;
    localparam logic [7:0] TWO_BYTE_MAX  = 8'hDF;
    localparam int unsigned MAX_TX_BITS  = 30;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    function automatic logic is_system(input logic [7:0] b);
        return b >= SYSTEM_MIN;
    endfunction

    function automatic logic is_status(input logic [7:0] b);
        return (b >= STATUS_MIN) && (b < SYSTEM_MIN);
    endfunction

    // Total message length in bytes (status included) for a channel status byte.
    function automatic logic [1:0] msg_len(input logic [7:0] status);
        return ((status >= TWO_BYTE_MIN) && (status <= TWO_BYTE_MAX)) ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button: 2-flop synchronizer plus consecutive-disagreement debounce counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pressed
);

    // State flips on the (2^N-1)th consecutive disagreeing cycle.
    localparam logic [DEBOUNCE_CNT-1:0] CNT_LAST = DEBOUNCE_CNT'((64'd1 << DEBOUNCE_CNT) - 64'd2);

    logic                    meta;
    logic                    sync;
    logic [DEBOUNCE_CNT-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            if (!sync != pressed) begin
                if (cnt == CNT_LAST) begin
                    pressed <= !sync;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/midi_io.sv
// MIDI front panel: debounced button select with save mode, MIDI byte receiver/parser
// and framed MIDI message transmitter.
module midi_io #(
    parameter int unsigned BIT_TICKS    = 3200,
    parameter int unsigned DEBOUNCE_CNT = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       board_btn,
    input  logic       btn2_pin_1,
    input  logic       btn2_pin_2,
    input  logic [1:0] midi_in_state,
    output logic [1:0] btn_index,
    output logic       save_mode,
    input  logic       midi_rx,
    output logic       rx_done,
    output logic [7:0] rx_status,
    output logic [7:0] rx_data1,
    output logic [7:0] rx_data2,
    output logic [1:0] rx_bytes,
    input  logic [7:0] tx_status,
    input  logic [7:0] tx_data1,
    input  logic [7:0] tx_data2,
    input  logic [7:0] tx_bits,
    input  logic       tx_trigger,
    output logic       midi_tx,
    output logic       tx_busy
);

    import midi_pkg::*;

    localparam int unsigned TICK_W = ($clog2(BIT_TICKS) < 1) ? 1 : $clog2(BIT_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(BIT_TICKS / 2 - 1);

    // ---------------- buttons ----------------
    logic [2:0] pressed;
    logic [1:0] prev_index;

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_board (
        .clk(clk), .rst(rst), .btn(board_btn), .pressed(pressed[0]));
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_pin1 (
        .clk(clk), .rst(rst), .btn(btn2_pin_1), .pressed(pressed[1]));
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_pin2 (
        .clk(clk), .rst(rst), .btn(btn2_pin_2), .pressed(pressed[2]));

    // The selected button keeps its index while held; otherwise pick by priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_index  <= 2'd0;
            prev_index <= 2'd0;
            save_mode  <= 1'b0;
        end else begin
            prev_index <= btn_index;
            if (btn_index != 2'd0 && pressed[btn_index - 2'd1]) begin
                btn_index <= btn_index;
            end else if (pressed[0]) begin
                btn_index <= 2'd1;
            end else if (pressed[1]) begin
                btn_index <= 2'd2;
            end else if (pressed[2]) begin
                btn_index <= 2'd3;
            end else begin
                btn_index <= 2'd0;
            end
            if (btn_index == 2'd0) begin
                save_mode <= 1'b0;
            end else if (prev_index == 2'd0 && midi_in_state == 2'd1) begin
                save_mode <= 1'b1;
            end
        end
    end

    // ---------------- RX byte receiver ----------------
    rx_state_t         rx_state;
    logic [TICK_W-1:0] rx_tick;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              rx_meta, rx_sync, rx_prev;
    logic              byte_stb;
    logic [7:0]        byte_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_tick  <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            byte_stb <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            rx_meta  <= midi_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            byte_stb <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_tick  <= '0;
                    end
                end
                RX_START: begin
                    if (rx_tick == HALF_LAST) begin
                        rx_tick  <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick <= rx_tick + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick == TICK_LAST) begin
                        rx_tick  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_tick <= rx_tick + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick == TICK_LAST) begin
                        rx_tick  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_stb <= 1'b1;
                            byte_q   <= rx_shift;
                        end
                    end else begin
                        rx_tick <= rx_tick + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX message parser (running status aware) ----------------
    logic       have_status;
    logic [7:0] run_status;
    logic [1:0] exp_len;
    logic       data_idx;
    logic [7:0] data1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            have_status <= 1'b0;
            run_status  <= 8'h00;
            exp_len     <= 2'd3;
            data_idx    <= 1'b0;
            data1_q     <= 8'h00;
            rx_done     <= 1'b0;
            rx_status   <= 8'h00;
            rx_data1    <= 8'h00;
            rx_data2    <= 8'h00;
            rx_bytes    <= 2'd0;
        end else if (byte_stb && !is_system(byte_q)) begin
            if (is_status(byte_q)) begin
                have_status <= 1'b1;
                run_status  <= byte_q;
                exp_len     <= msg_len(byte_q);
                data_idx    <= 1'b0;
                rx_done     <= 1'b0;
            end else if (have_status) begin
                if (!data_idx && exp_len == 2'd2) begin
                    rx_status <= run_status;
                    rx_data1  <= byte_q;
                    rx_data2  <= 8'h00;
                    rx_bytes  <= 2'd2;
                    rx_done   <= 1'b1;
                end else if (!data_idx) begin
                    data1_q  <= byte_q;
                    data_idx <= 1'b1;
                    rx_done  <= 1'b0;
                end else begin
                    rx_status <= run_status;
                    rx_data1  <= data1_q;
                    rx_data2  <= byte_q;
                    rx_bytes  <= 2'd3;
                    rx_done   <= 1'b1;
                    data_idx  <= 1'b0;
                end
            end
        end
    end

    // ---------------- TX ----------------
    tx_state_t         tx_state;
    logic [TICK_W-1:0] tx_tick;
    logic [4:0]        tx_left;
    logic [28:0]       tx_shift;
    logic              trig_prev;
    logic [4:0]        tx_count_c;
    logic [29:0]       tx_frame_c;

    assign tx_count_c = (tx_bits > 8'(MAX_TX_BITS)) ? 5'(MAX_TX_BITS) : tx_bits[4:0];
    assign tx_frame_c = {1'b1, tx_data2, 1'b0, 1'b1, tx_data1, 1'b0, 1'b1, tx_status, 1'b0};

    // Frame is latched whole; bits leave LSB first, one per BIT_TICKS cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state  <= TX_IDLE;
            tx_tick   <= '0;
            tx_left   <= 5'd0;
            tx_shift  <= '1;
            trig_prev <= 1'b0;
            midi_tx   <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            trig_prev <= tx_trigger;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_trigger && !trig_prev && tx_count_c != 5'd0) begin
                        tx_state <= TX_SEND;
                        midi_tx  <= tx_frame_c[0];
                        tx_shift <= tx_frame_c[29:1];
                        tx_left  <= tx_count_c;
                        tx_tick  <= '0;
                        tx_busy  <= 1'b1;
                    end
                end
                TX_SEND: begin
                    if (tx_tick == TICK_LAST) begin
                        tx_tick <= '0;
                        if (tx_left == 5'd1) begin
                            tx_state <= TX_IDLE;
                            midi_tx  <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else begin
                            midi_tx  <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[28:1]};
                            tx_left  <= tx_left - 5'd1;
                        end
                    end else begin
                        tx_tick <= tx_tick + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_io.sv
// Randomized scoreboard bench for midi_io: message-level RX model, bit-level TX model.
module tb_midi_io;

    localparam int unsigned BT = 16;
    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       board_btn = 1'b1, btn2_pin_1 = 1'b1, btn2_pin_2 = 1'b1;
    logic [1:0] midi_in_state = 2'd0;
    logic [1:0] btn_index;
    logic       save_mode;
    logic       midi_rx = 1'b1;
    logic       rx_done;
    logic [7:0] rx_status, rx_data1, rx_data2;
    logic [1:0] rx_bytes;
    logic [7:0] tx_status = 8'h00, tx_data1 = 8'h00, tx_data2 = 8'h00, tx_bits = 8'h00;
    logic       tx_trigger = 1'b0;
    logic       midi_tx;
    logic       tx_busy;

    always #5 clk = ~clk;

    midi_io #(.BIT_TICKS(BT), .DEBOUNCE_CNT(DB)) dut (
        .clk(clk), .rst(rst),
        .board_btn(board_btn), .btn2_pin_1(btn2_pin_1), .btn2_pin_2(btn2_pin_2),
        .midi_in_state(midi_in_state), .btn_index(btn_index), .save_mode(save_mode),
        .midi_rx(midi_rx), .rx_done(rx_done), .rx_status(rx_status),
        .rx_data1(rx_data1), .rx_data2(rx_data2), .rx_bytes(rx_bytes),
        .tx_status(tx_status), .tx_data1(tx_data1), .tx_data2(tx_data2),
        .tx_bits(tx_bits), .tx_trigger(tx_trigger), .midi_tx(midi_tx), .tx_busy(tx_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- RX reference model: visible output state per received byte ----------------
    typedef logic [26:0] vis_t;   // {done, status, data1, data2, bytes}
    vis_t       rx_exp_q[$];
    vis_t       model_vis = '0;
    vis_t       mon_last  = '0;
    bit         m_have = 0, m_done = 0;
    logic [7:0] m_run = 0, m_st = 0, m_d1 = 0, m_d2 = 0;
    logic [1:0] m_by = 0;
    int         m_need = 2;
    logic [7:0] m_data[$];

    task automatic model_push();
        vis_t v;
        v = {m_done, m_st, m_d1, m_d2, m_by};
        if (v !== model_vis) begin
            rx_exp_q.push_back(v);
            model_vis = v;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'hF0) begin
            // system bytes are invisible to the parser
        end else if (b >= 8'h80) begin
            m_have = 1; m_run = b; m_done = 0; m_data.delete();
            m_need = (b >= 8'hC0 && b <= 8'hDF) ? 1 : 2;
        end else if (m_have) begin
            m_done = 0;
            m_data.push_back(b);
            if (m_data.size() == m_need) begin
                m_st = m_run;
                m_d1 = m_data[0];
                m_d2 = (m_need == 2) ? m_data[1] : 8'h00;
                m_by = 2'(m_need + 1);
                m_done = 1;
                m_data.delete();
            end
        end
        model_push();
    endtask

    task automatic model_reset();
        m_have = 0; m_done = 0; m_run = 0; m_st = 0; m_d1 = 0; m_d2 = 0; m_by = 0;
        m_data.delete();
        model_push();
    endtask

    // RX monitor: every change of the visible outputs must match the next predicted state.
    always @(negedge clk) begin
        vis_t cur;
        cur = {rx_done, rx_status, rx_data1, rx_data2, rx_bytes};
        if (cur !== mon_last) begin
            mon_last = cur;
            if (rx_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rx_unexpected: got %h expected no change", cur);
            end else begin
                chk("rx_msg", 32'(cur), 32'(rx_exp_q.pop_front()));
            end
        end
    end

    // ---------------- TX expectation and monitor ----------------
    logic tx_bit_q[$];
    int   tx_len_q[$];
    int   tx_cyc = 0;
    bit   tx_prev_busy = 0;

    always @(negedge clk) begin
        if (!rst) begin
            tx_cyc = 0; tx_prev_busy = 0;
            tx_bit_q.delete(); tx_len_q.delete();
        end else begin
            if (tx_busy) begin
                if ((tx_cyc % BT) == BT / 2) begin
                    if (tx_bit_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_extra_bit: got %0b expected none", midi_tx);
                    end else begin
                        chk("tx_bit", 32'(midi_tx), 32'(tx_bit_q.pop_front()));
                    end
                end
                tx_cyc++;
            end else if (tx_prev_busy) begin
                if (tx_len_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected_frame: got %0d cycles expected none", tx_cyc);
                end else begin
                    chk("tx_busy_len", 32'(tx_cyc), 32'(tx_len_q.pop_front()));
                end
                chk("tx_idle_level", 32'(midi_tx), 32'd1);
                tx_cyc = 0;
            end
            tx_prev_busy = tx_busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input bit good_stop, input int gap);
        if (good_stop) model_byte(b);
        @(negedge clk) midi_rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (BT) @(negedge clk);
        end
        midi_rx = good_stop;
        repeat (BT) @(negedge clk);
        midi_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic tx_send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] nbits, input int hold);
        int n;
        logic [7:0] by [3];
        n = (nbits > 8'd30) ? 30 : int'(nbits);
        by[0] = s; by[1] = d1; by[2] = d2;
        for (int i = 0; i < n; i++) begin
            int p;
            logic v;
            p = i % 10;
            if (p == 0) v = 1'b0;
            else if (p == 9) v = 1'b1;
            else v = by[i / 10][p - 1];
            tx_bit_q.push_back(v);
        end
        if (n > 0) tx_len_q.push_back(n * BT);
        @(negedge clk);
        tx_status = s; tx_data1 = d1; tx_data2 = d2; tx_bits = nbits; tx_trigger = 1'b1;
        repeat (hold) @(negedge clk);
        tx_trigger = 1'b0;
    endtask

    task automatic wait_tx_idle(input int budget);
        int k;
        k = 0;
        while (tx_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (tx_busy) begin
            checks++; errors++;
            $display("FAIL tx_timeout: got busy expected idle within %0d", budget);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic button_wait(input int n, output bit seen_nonzero);
        seen_nonzero = 0;
        repeat (n) begin
            @(negedge clk);
            if (btn_index != 2'd0) seen_nonzero = 1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        repeat (4) @(negedge clk);
        chk("rst_btn_index", 32'(btn_index), 0);
        chk("rst_save_mode", 32'(save_mode), 0);
        chk("rst_rx_done", 32'(rx_done), 0);
        chk("rst_rx_status", 32'(rx_status), 0);
        chk("rst_rx_bytes", 32'(rx_bytes), 0);
        chk("rst_midi_tx", 32'(midi_tx), 1);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // buttons
        btn2_pin_1 = 1'b0;
        repeat (20) @(negedge clk);
        chk("btn_pin1_index", 32'(btn_index), 2);
        btn2_pin_1 = 1'b1;
        repeat (25) @(negedge clk);
        chk("btn_pin1_release", 32'(btn_index), 0);
        btn2_pin_1 = 1'b0;
        repeat (10) @(negedge clk);
        btn2_pin_1 = 1'b1;
        button_wait(30, seen);
        chk("btn_glitch_ignored", 32'(seen), 0);
        midi_in_state = 2'd1;
        board_btn = 1'b0;
        repeat (25) @(negedge clk);
        chk("save_btn_index", 32'(btn_index), 1);
        chk("save_mode_set", 32'(save_mode), 1);
        midi_in_state = 2'd0;
        repeat (5) @(negedge clk);
        chk("save_mode_hold", 32'(save_mode), 1);
        board_btn = 1'b1;
        repeat (25) @(negedge clk);
        chk("save_release_index", 32'(btn_index), 0);
        chk("save_release_mode", 32'(save_mode), 0);
        btn2_pin_2 = 1'b0;
        repeat (25) @(negedge clk);
        chk("nosave_index", 32'(btn_index), 3);
        chk("nosave_mode", 32'(save_mode), 0);
        btn2_pin_2 = 1'b1;
        repeat (25) @(negedge clk);

        // RX directed
        send_byte(8'h55, 1, BT);          // no status yet: discarded
        @(negedge clk) midi_rx = 1'b0;    // start-bit glitch
        repeat (3) @(negedge clk);
        midi_rx = 1'b1;
        repeat (3 * BT) @(negedge clk);
        send_byte(8'hB0, 1, BT);
        send_byte(8'h2E, 1, BT);
        send_byte(8'h7F, 1, BT);
        chk("rx_b0_done", 32'(rx_done), 1);
        chk("rx_b0_d2", 32'(rx_data2), 32'h7F);
        send_byte(8'hC0, 1, BT);
        send_byte(8'h42, 1, BT);
        send_byte(8'h43, 1, BT);
        chk("rx_run_d1", 32'(rx_data1), 32'h43);
        chk("rx_run_bytes", 32'(rx_bytes), 2);

        // RX randomized
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 9));
            if (r < 2) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r == 2) b = 8'($urandom_range(8'hF0, 8'hFF));
            else b = 8'($urandom_range(0, 8'h7F));
            send_byte(b, 1, int'($urandom_range(BT, BT + 20)));
        end

        // TX directed
        tx_send(8'hB0, 8'h2F, 8'h7F, 8'd30, 1);
        chk("tx_busy_start", 32'(tx_busy), 1);
        wait_tx_idle(600);
        tx_send(8'h90, 8'h11, 8'h22, 8'd0, 1);
        repeat (3) @(negedge clk);
        chk("tx_zero_bits_idle", 32'(tx_busy), 0);
        tx_send(8'($urandom), 8'($urandom), 8'($urandom), 8'd45, 1);
        wait_tx_idle(600);
        tx_send(8'($urandom), 8'($urandom), 8'($urandom), 8'd20, 1);
        repeat (50) @(negedge clk);
        tx_status = 8'h12; tx_trigger = 1'b1;   // edge while busy: ignored
        @(negedge clk) tx_trigger = 1'b0;
        wait_tx_idle(600);
        tx_send(8'($urandom), 8'($urandom), 8'($urandom), 8'd10, 400);  // level held past the end
        wait_tx_idle(600);

        // reset mid-TX with a message on display
        tx_send(8'hB0, 8'h2F, 8'h7F, 8'd30, 1);
        repeat (100) @(negedge clk);
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_tx_line", 32'(midi_tx), 1);
        chk("rst_mid_tx_busy", 32'(tx_busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rx_cleared", 32'(rx_done), 0);
        send_byte(8'h12, 1, BT);          // no status since reset
        send_byte(8'hB0, 1, BT);
        send_byte(8'h11, 1, BT);
        send_byte(8'h22, 0, 2 * BT);      // bad stop bit: dropped
        send_byte(8'h33, 1, BT);
        chk("rx_badstop_d2", 32'(rx_data2), 32'h33);

        repeat (20) @(negedge clk);
        chk("rx_queue_drained", 32'(rx_exp_q.size()), 0);
        chk("tx_queue_drained", 32'(tx_bit_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
